// File: rtl/dilithium_job_arbiter.sv
// Round-robin arbiter sharing one Dilithium core among NUM_REQ clients, with stream muxing,
// job release on completion and a watchdog that resets a hung core.
module dilithium_job_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WDOG_CYC = 2**20,
  parameter int unsigned RST_CYC  = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [2*NUM_REQ-1:0]    mode_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      done_o,
  output logic [NUM_REQ-1:0]      err_o,
  input  logic [NUM_REQ-1:0]      cl_valid_i,
  output logic [NUM_REQ-1:0]      cl_ready_i,
  input  logic [32*NUM_REQ-1:0]   cl_data_i,
  output logic [NUM_REQ-1:0]      cl_valid_o,
  input  logic [NUM_REQ-1:0]      cl_ready_o,
  output logic [31:0]             cl_data_o,
  output logic                    core_start,
  output logic [1:0]              core_mode,
  output logic                    core_valid_i,
  output logic [31:0]             core_data_i,
  input  logic                    core_ready_i,
  input  logic                    core_valid_o,
  input  logic [31:0]             core_data_o,
  output logic                    core_ready_o,
  input  logic                    core_done,
  output logic                    core_rst,
  output logic                    busy_o,
  output logic [IDX_W-1:0]        owner_o
);

  localparam int unsigned SUM_W  = IDX_W + 1;
  localparam int unsigned WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam int unsigned RST_W  = $clog2(RST_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((WDOG_CYC == 0) ? 0 : WDOG_CYC - 1);
  localparam logic [RST_W-1:0]  RST_INIT  = RST_W'(RST_CYC);
  localparam logic [RST_W-1:0]  RST_ABORT = RST_W'(RST_CYC - 1);

  typedef enum logic [2:0] {StIdle, StStart, StRun, StRelease, StAbort} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    owner_q, rr_q, pick, off;
  logic [NUM_REQ-1:0]  gnt_q, done_q, err_q, owner_oh, rot;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [SUM_W-1:0]    sum;
  logic [1:0]          pick_mode, own_mode, core_mode_q;
  logic                core_start_q, core_rst_q, req_any, run, hs, complete, wdog_expire;
  logic [WDOG_W-1:0]   wdog_q;
  logic [RST_W-1:0]    rst_cnt_q;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Rotate requests so bit 0 is rr_q, take the lowest set bit, then rotate the index back.
  always_comb begin
    req_dbl = {req_i, req_i} >> rr_q;
    rot     = req_dbl[NUM_REQ-1:0];
    off     = '0;
    req_any = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off     = IDX_W'(j);
        req_any = 1'b1;
      end
    end
    sum  = {1'b0, rr_q} + {1'b0, off};
    pick = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ)) : sum[IDX_W-1:0];
  end

  always_comb begin
    pick_mode   = '0;
    own_mode    = '0;
    core_data_i = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == IDX_W'(k)) pick_mode = mode_i[2*k +: 2];
      if (owner_q == IDX_W'(k)) begin
        own_mode    = mode_i[2*k +: 2];
        core_data_i = cl_data_i[32*k +: 32];
      end
    end
  end

  assign run          = (state_q == StRun);
  assign owner_oh     = NUM_REQ'(1) << owner_q;
  assign core_valid_i = run & |(cl_valid_i & owner_oh);
  assign core_ready_o = run & |(cl_ready_o & owner_oh);
  assign cl_ready_i   = (run && core_ready_i) ? owner_oh : '0;
  assign cl_valid_o   = (run && core_valid_o) ? owner_oh : '0;
  assign cl_data_o    = core_data_o;
  assign hs           = (core_valid_i & core_ready_i) | (core_valid_o & core_ready_o);
  // A result word still waiting on the client must drain before the job can finish.
  assign complete     = core_done & ~(core_valid_o & ~|(cl_ready_o & owner_oh));
  assign wdog_expire  = (WDOG_CYC != 0) && (wdog_q == WDOG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      rr_q         <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      core_start_q <= 1'b0;
      core_mode_q  <= '0;
      core_rst_q   <= 1'b1;
      rst_cnt_q    <= RST_INIT;
      wdog_q       <= '0;
    end else begin
      done_q       <= '0;
      err_q        <= '0;
      core_start_q <= 1'b0;
      if (rst_cnt_q != '0) rst_cnt_q <= rst_cnt_q - RST_W'(1);
      core_rst_q <= (rst_cnt_q != '0);
      unique case (state_q)
        StIdle: begin
          if (!core_rst_q && req_any) begin
            owner_q <= pick;
            if (pick_mode == 2'd3) begin
              err_q <= NUM_REQ'(1) << pick;
              rr_q  <= next_idx(pick);
            end else begin
              state_q <= StStart;
            end
          end
        end
        StStart: begin
          gnt_q        <= owner_oh;
          core_start_q <= 1'b1;
          core_mode_q  <= own_mode;
          wdog_q       <= '0;
          state_q      <= StRun;
        end
        StRun: begin
          if (complete) begin
            done_q  <= owner_oh;
            state_q <= StRelease;
          end else if (hs) begin
            wdog_q <= '0;
          end else if (wdog_expire) begin
            core_rst_q <= 1'b1;
            rst_cnt_q  <= RST_ABORT;
            if (RST_CYC <= 1) err_q <= owner_oh;
            state_q    <= StAbort;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        StRelease: begin
          gnt_q   <= '0;
          rr_q    <= next_idx(owner_q);
          state_q <= StIdle;
        end
        StAbort: begin
          // err lands on the final abort cycle, the one where the counter reads zero.
          if (rst_cnt_q == RST_W'(1)) err_q <= owner_oh;
          if (rst_cnt_q == '0) begin
            gnt_q   <= '0;
            rr_q    <= next_idx(owner_q);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign core_start = core_start_q;
  assign core_mode  = core_mode_q;
  assign core_rst   = core_rst_q;
  assign busy_o     = (state_q != StIdle);
  assign owner_o    = owner_q;

endmodule
